// File: rtl/mem_stream_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stream_ctrl
//
// Streaming FIFO controller wrapped around an external dual-port memory
// (synchronous write, combinational read). Incoming words are written into the
// memory. The word at the read pointer is prefetched into a registered output
// stage whenever that stage is empty or being drained. The memory and the
// output register together form a SIZE+1 entry elastic buffer.
//
// Optional build macro:
//   MEM_STREAM_BYPASS_EN - when the memory is empty and the output register
//                          can be loaded, an incoming word goes straight into
//                          the output register. It is never written to memory,
//                          which gives a 1-cycle empty latency instead of 2.
//
// Ports:
//   clk           clock, all state on rising edge
//   reset         asynchronous active-high reset
//   in_data       input stream word
//   in_valid      in_data valid
//   in_ready      controller accepts a word this cycle
//   mem_data_in   memory write data (in_data pass-through)
//   mem_wr_addr   memory write address (write pointer)
//   mem_wr_en     memory write enable
//   mem_rd_addr   memory read address (read pointer)
//   mem_data_out  memory combinational read data at mem_rd_addr
//   out_data      registered output word
//   out_valid     out_data valid
//   out_ready     downstream accepts out_data
//   mem_count     words held in memory (output register excluded)
// -----------------------------------------------------------------------------
module mem_stream_ctrl #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 64,
    parameter int LSIZE = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] mem_data_in,
    output logic [LSIZE-1:0] mem_wr_addr,
    output logic             mem_wr_en,
    output logic [LSIZE-1:0] mem_rd_addr,
    input  logic [WIDTH-1:0] mem_data_out,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LSIZE:0]   mem_count
);

    localparam logic [LSIZE-1:0] PTR_LAST = LSIZE'(SIZE - 1);
    localparam logic [LSIZE-1:0] PTR_ONE  = LSIZE'(1);
    localparam logic [LSIZE:0]   CNT_FULL = (LSIZE + 1)'(SIZE);
    localparam logic [LSIZE:0]   CNT_ONE  = (LSIZE + 1)'(1);

    logic [LSIZE-1:0] r_wr_ptr;
    logic [LSIZE-1:0] r_rd_ptr;
    logic [LSIZE:0]   r_mem_count;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;

    logic [LSIZE-1:0] w_wr_ptr_next;
    logic [LSIZE-1:0] w_rd_ptr_next;
    logic [LSIZE:0]   w_mem_count_next;
    logic [WIDTH-1:0] w_out_data_next;
    logic             w_out_valid_next;

    logic w_in_ready;
    logic w_push;
    logic w_pop;
    logic w_load_ok;
    logic w_load;
    logic w_bypass;
    logic w_mem_write;

    // in_ready depends only on the registered count (plus reset, so nothing is
    // accepted while reset is held). It has no path from out_ready.
    assign w_in_ready = !reset && (r_mem_count != CNT_FULL);
    assign w_push     = in_valid && w_in_ready;
    assign w_pop      = r_out_valid && out_ready;
    assign w_load_ok  = !r_out_valid || w_pop;
    assign w_load     = w_load_ok && (r_mem_count != '0);

`ifdef MEM_STREAM_BYPASS_EN
    // Memory empty and output stage free: skip the memory entirely.
    assign w_bypass = w_push && w_load_ok && (r_mem_count == '0);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_mem_write = w_push && !w_bypass;

    always_comb begin
        w_wr_ptr_next    = r_wr_ptr;
        w_rd_ptr_next    = r_rd_ptr;
        w_mem_count_next = r_mem_count;
        w_out_data_next  = r_out_data;
        w_out_valid_next = r_out_valid;

        if (w_mem_write) begin
            w_wr_ptr_next = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_ONE;
        end

        if (w_load) begin
            w_rd_ptr_next = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_ONE;
        end

        // Write and prefetch in the same cycle cancel out.
        if (w_mem_write && !w_load) begin
            w_mem_count_next = r_mem_count + CNT_ONE;
        end else if (w_load && !w_mem_write) begin
            w_mem_count_next = r_mem_count - CNT_ONE;
        end

        // load and bypass are mutually exclusive: load needs a non-empty
        // memory, bypass needs an empty one.
        if (w_bypass) begin
            w_out_data_next  = in_data;
            w_out_valid_next = 1'b1;
        end else if (w_load) begin
            w_out_data_next  = mem_data_out;
            w_out_valid_next = 1'b1;
        end else if (w_pop) begin
            w_out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_count <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_next;
            r_rd_ptr    <= w_rd_ptr_next;
            r_mem_count <= w_mem_count_next;
            r_out_data  <= w_out_data_next;
            r_out_valid <= w_out_valid_next;
        end
    end

    assign in_ready    = w_in_ready;
    assign mem_data_in = in_data;
    assign mem_wr_addr = r_wr_ptr;
    assign mem_wr_en   = w_mem_write;
    assign mem_rd_addr = r_rd_ptr;
    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign mem_count   = r_mem_count;

endmodule

// File: tb/tb_mem_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stream_ctrl
//
// Bench for mem_stream_ctrl with a behavioural dual-port memory (synchronous
// write, combinational read). Accepted input words are pushed to a scoreboard
// queue; every output pop is compared against the queue head. Directed phases
// cover reset, empty latency, full, single pop from full, random back-pressure
// across pointer wrap, steady-state throughput and reset mid-stream.
// Build with MEM_STREAM_BYPASS_EN to check the bypass variant.
// -----------------------------------------------------------------------------
module tb_mem_stream_ctrl;

    localparam int WIDTH = 16;
    localparam int SIZE  = 64;
    localparam int LSIZE = $clog2(SIZE);

`ifdef MEM_STREAM_BYPASS_EN
    localparam int SS_COUNT = 0;
`else
    localparam int SS_COUNT = 1;
`endif

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] mem_data_in;
    logic [LSIZE-1:0] mem_wr_addr;
    logic             mem_wr_en;
    logic [LSIZE-1:0] mem_rd_addr;
    logic [WIDTH-1:0] mem_data_out;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [LSIZE:0]   mem_count;

    mem_stream_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE), .LSIZE(LSIZE)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_data_in  (mem_data_in),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_en    (mem_wr_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_data_out (mem_data_out),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .mem_count    (mem_count)
    );

    // Behavioural memory.
    logic [WIDTH-1:0] mem_model [SIZE];
    initial begin
        for (int i = 0; i < SIZE; i++) mem_model[i] = '0;
    end
    always @(posedge clk) begin
        if (mem_wr_en) mem_model[mem_wr_addr] <= mem_data_in;
    end
    assign mem_data_out = mem_model[mem_rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] exp_q [$];
    bit               in_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance past the next rising edge; inputs and samples happen here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until the controller takes it.
    task automatic push_word(input logic [WIDTH-1:0] w);
        int n;
        in_data  = w;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) chk("push_timeout", 32'd1, 32'd0);
        tick();
    endtask

    task automatic drain(input string tag);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
        chk(tag, exp_q.size(), 32'd0);
        out_ready = 1'b0;
    endtask

    // Scoreboard monitor, sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (!reset) begin
            if (in_valid && in_ready) exp_q.push_back(in_data);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    $display("pop data=0x%04h expected=0x%04h count=%0d", out_data, e, mem_count);
                    chk("pop_data", 32'(out_data), 32'(e));
                end
            end
            chk("count_le_size", 32'(mem_count <= SIZE), 32'd1);
        end
    end

    initial begin
        int n;
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_done   = 1'b0;

        // Reset state.
        #3;
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_count",     32'(mem_count), 32'd0);
        tick(); tick(); tick();
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Empty latency with single word 0x1111.
        out_ready = 1'b1;
        in_data   = 16'h1111;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef MEM_STREAM_BYPASS_EN
        chk("lat_valid_e1", 32'(out_valid), 32'd1);
        chk("lat_data_e1",  32'(out_data),  32'h1111);
        chk("lat_count_e1", 32'(mem_count), 32'd0);
`else
        chk("lat_valid_e1", 32'(out_valid), 32'd0);
        chk("lat_count_e1", 32'(mem_count), 32'd1);
        tick();
        chk("lat_valid_e2", 32'(out_valid), 32'd1);
        chk("lat_data_e2",  32'(out_data),  32'h1111);
        chk("lat_count_e2", 32'(mem_count), 32'd0);
`endif
        tick();
        chk("lat_drained", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Fill: 65 words 0x0000..0x0040 with out_ready low.
        for (int i = 0; i <= 64; i++) push_word(16'(i));
        in_data  = 16'h0041;
        in_valid = 1'b1;
        #1;
        chk("full_count",     32'(mem_count), 32'd64);
        chk("full_in_ready",  32'(in_ready),  32'd0);
        chk("full_wr_en",     32'(mem_wr_en), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_out_data",  32'(out_data),  32'h0000);
        tick(); tick();
        chk("stall_out_data", 32'(out_data),  32'h0000);
        chk("stall_count",    32'(mem_count), 32'd64);
        in_valid = 1'b0;

        // Single pop from full.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pop1_out_data", 32'(out_data),  32'h0001);
        chk("pop1_count",    32'(mem_count), 32'd63);
        chk("pop1_in_ready", 32'(in_ready),  32'd1);

        // 200 incrementing words with random back-pressure across wrap.
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(3) == 0) begin
                        in_valid = 1'b0;
                        tick();
                    end
                    push_word(16'h0100 + 16'(i));
                end
                in_valid = 1'b0;
                in_done  = 1'b1;
            end
            begin
                n = 0;
                while ((!in_done || exp_q.size() != 0) && n < 5000) begin
                    out_ready = 1'($urandom_range(1));
                    tick();
                    n++;
                end
                chk("stream_done", 32'(n < 5000), 32'd1);
                out_ready = 1'b0;
            end
        join
        drain("stream_drain");

        // Steady state: push and pop every cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push_word(16'h0400 + 16'(i));
            if (i >= 2) begin
                chk("ss_count", 32'(mem_count), 32'(SS_COUNT));
                chk("ss_valid", 32'(out_valid), 32'd1);
            end
        end
        in_valid = 1'b0;
        drain("ss_drain");

        // Reset mid-stream with 10 words in memory and output valid.
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) push_word(16'h0200 + 16'(i));
        in_valid = 1'b0;
        tick();
        chk("mid_count", 32'(mem_count), 32'd10);
        chk("mid_valid", 32'(out_valid), 32'd1);
        in_data  = 16'hDEAD;
        in_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("mrst_valid",    32'(out_valid), 32'd0);
        chk("mrst_count",    32'(mem_count), 32'd0);
        chk("mrst_in_ready", 32'(in_ready),  32'd0);
        chk("mrst_wr_en",    32'(mem_wr_en), 32'd0);
        exp_q.delete();
        tick(); tick();
        in_valid = 1'b0;
        reset    = 1'b0;
        tick();
        out_ready = 1'b1;
        push_word(16'hBEEF);
        in_valid = 1'b0;
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("beef_data", 32'(out_data), 32'hBEEF);
        drain("final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
